alarme_central: RTL and testbench

ALARME_CENTRAL -- requirements
Module: alarme_central

---
 rtl/alarme_pkg.sv | 14 +
 rtl/alarme_central_if.sv | 21 ++
 rtl/alarme_central_temporizador.sv | 17 +
 rtl/alarme_central.sv | 71 +++++++
 tb/tb_alarme_central.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/alarme_pkg.sv
// alarme_pkg: state codes, state width and counter sizing helper shared by the alarm central
package alarme_pkg;
  localparam int EST_W = 3;
  typedef enum logic [EST_W-1:0] {
    DESARMADO = 3'd0,
    SAIDA     = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    DISPARO   = 3'd4
  } estado_t;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/alarme_central_if.sv
// alarme_central_if: keypad/sensor inputs and status outputs of the alarm central
interface alarme_central_if #(
  parameter int N_ZONAS = 4
) ();
  logic                      arm;
  logic                      disarm;
  logic [N_ZONAS-1:0]        zona;
  logic                      sirene;
  logic                      armado;
  logic                      pre_alarme;
  logic [N_ZONAS-1:0]        memoria;
  logic [alarme_pkg::EST_W-1:0] estado;
  modport master (
    output arm, disarm, zona,
    input  sirene, armado, pre_alarme, memoria, estado
  );
  modport slave (
    input  arm, disarm, zona,
    output sirene, armado, pre_alarme, memoria, estado
  );
endinterface

// File: rtl/alarme_central_temporizador.sv
// temporizador: loadable down-counter that parks at zero and flags it
module temporizador #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign done_o = cnt_q == '0;
  assign cnt_d  = load_i ? val_i : done_o ? cnt_q : cnt_q - 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/alarme_central.sv
// alarme_central: zoned burglar alarm FSM with exit/entry delays, timed siren,
// alarm memory and auto re-arm that bypasses zones which caused the last alarm
module alarme_central
  import alarme_pkg::*;
#(
  parameter int                 N_ZONAS     = 4,
  parameter logic [N_ZONAS-1:0] DELAY_MASK  = N_ZONAS'(4'b0001),
  parameter int                 EXIT_DELAY  = 8,
  parameter int                 ENTRY_DELAY = 8,
  parameter int                 SIREN_TIME  = 16
) (
  input logic             clk,
  input logic             rst_n,
  alarme_central_if.slave ctl
);
  localparam int CW = $clog2(max3(EXIT_DELAY, ENTRY_DELAY, SIREN_TIME) + 1);
  estado_t            st_q, st_d;
  logic [N_ZONAS-1:0] mem_q, mem_d, byp_q, byp_d, act;
  logic [CW-1:0]      ld_val;
  logic               done;
  assign act = ctl.zona & ~byp_q;
  // the counter is reloaded on every state change with the length of the state entered
  assign ld_val = (st_d == SAIDA)   ? CW'(EXIT_DELAY - 1)  :
                  (st_d == ENTRADA) ? CW'(ENTRY_DELAY - 1) :
                  (st_d == DISPARO) ? CW'(SIREN_TIME - 1)  : '0;
  temporizador #(.W(CW)) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (st_d != st_q),
    .val_i  (ld_val),
    .done_o (done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q  <= DESARMADO;
      mem_q <= '0;
      byp_q <= '0;
    end else begin
      st_q  <= st_d;
      mem_q <= mem_d;
      byp_q <= byp_d;
    end
  always_comb begin
    st_d  = st_q;
    byp_d = byp_q;
    mem_d = (st_q inside {ARMADO, ENTRADA, DISPARO}) ? mem_q | act : mem_q;
    if (ctl.disarm) st_d = DESARMADO;
    else
      case (st_q)
        DESARMADO: if (ctl.arm) begin
          st_d  = SAIDA;
          mem_d = '0;
          byp_d = '0;
        end
        SAIDA:   st_d = done ? ARMADO : SAIDA;
        ARMADO:  st_d = |(act & ~DELAY_MASK) ? DISPARO : |(act & DELAY_MASK) ? ENTRADA : ARMADO;
        ENTRADA: st_d = (done || |(act & ~DELAY_MASK)) ? DISPARO : ENTRADA;
        // siren timeout: zones recorded so far stop retriggering until the next arm
        DISPARO: if (done) begin
          st_d  = ARMADO;
          byp_d = byp_q | mem_d;
        end
        default: st_d = DESARMADO;
      endcase
  end
  assign ctl.sirene     = st_q == DISPARO;
  assign ctl.armado     = st_q inside {ARMADO, ENTRADA, DISPARO};
  assign ctl.pre_alarme = st_q inside {SAIDA, ENTRADA};
  assign ctl.memoria    = mem_q;
  assign ctl.estado     = st_q;
endmodule

// File: tb/tb_alarme_central.sv
// tb_alarme_central: directed scenarios plus random traffic checked against a cycle-age alarm model
module tb_alarme_central;
  localparam int         NZ  = 4;
  localparam int         EXD = 8;
  localparam int         END = 8;
  localparam int         SIR = 16;
  localparam logic [3:0] DM  = 4'b0001;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int m_st, m_age;
  logic [3:0] m_mem, m_byp;
  alarme_central_if #(.N_ZONAS(NZ)) ctl ();
  alarme_central #(
    .N_ZONAS(NZ), .DELAY_MASK(DM), .EXIT_DELAY(EXD), .ENTRY_DELAY(END), .SIREN_TIME(SIR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctl(ctl)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_st = 0;
    m_age = 0;
    m_mem = '0;
    m_byp = '0;
  endtask
  // m_age counts cycles already spent in the current state, including the present one
  task automatic m_step(input logic a, input logic d, input logic [3:0] z);
    logic [3:0] act;
    int ns;
    act = z & ~m_byp;
    ns = m_st;
    if (m_st >= 2 && m_st <= 4) m_mem = m_mem | act;
    if (d) ns = 0;
    else if (m_st == 0 && a) begin ns = 1; m_mem = '0; m_byp = '0; end
    else if (m_st == 1 && m_age == EXD) ns = 2;
    else if (m_st == 2 && (act & ~DM) != 0) ns = 4;
    else if (m_st == 2 && act != 0) ns = 3;
    else if (m_st == 3 && ((act & ~DM) != 0 || m_age == END)) ns = 4;
    else if (m_st == 4 && m_age == SIR) begin ns = 2; m_byp = m_byp | m_mem; end
    m_age = (ns != m_st) ? 1 : m_age + 1;
    m_st = ns;
  endtask
  task automatic cmp_model();
    chk("estado", 32'(ctl.estado), 32'(m_st));
    chk("sir_arm_pre", 32'({ctl.sirene, ctl.armado, ctl.pre_alarme}),
        32'({m_st == 4, m_st >= 2, (m_st == 1 || m_st == 3)}));
    chk("memoria", 32'(ctl.memoria), 32'(m_mem));
  endtask
  task automatic cyc(input logic a, input logic d, input logic [3:0] z);
    ctl.arm = a;
    ctl.disarm = d;
    ctl.zona = z;
    m_step(a, d, z);
    @(negedge clk);
    cmp_model();
  endtask
  initial begin
    int k;
    logic seen;
    ctl.arm = 1'b0;
    ctl.disarm = 1'b0;
    ctl.zona = '0;
    m_reset();
    @(negedge clk);
    cmp_model();
    chk("rst_estado", 32'(ctl.estado), 0);
    rst_n = 1'b1;
    cyc(1, 1, 0);
    chk("arm_and_disarm", 32'(ctl.estado), 0);
    cyc(1, 0, 0);
    chk("arm_to_saida", 32'(ctl.estado), 1);
    repeat (EXD - 1) cyc(0, 0, 0);
    chk("saida_last", 32'(ctl.estado), 1);
    cyc(0, 0, 0);
    chk("exit_done", 32'(ctl.estado), 2);
    cyc(0, 0, 4'b0001);
    chk("entrada", 32'(ctl.estado), 3);
    seen = 1'b0;
    repeat (4) begin cyc(0, 0, 0); seen = seen | ctl.sirene; end
    cyc(0, 1, 0);
    chk("disarm_entrada", 32'(ctl.estado), 0);
    chk("no_siren", 32'(seen), 0);
    chk("mem_delayed", 32'(ctl.memoria), 1);
    cyc(1, 0, 0);
    repeat (EXD) cyc(0, 0, 0);
    chk("mem_cleared_on_arm", 32'(ctl.memoria), 0);
    cyc(0, 0, 4'b0001);
    k = 1;
    while (!ctl.sirene && k < 40) begin cyc(0, 0, 0); k++; end
    chk("entry_timeout_lat", 32'(k), 9);
    k = 0;
    while (ctl.sirene && k < 40) begin cyc(0, 0, 0); k++; end
    chk("siren_len", 32'(k), SIR);
    chk("auto_rearm", 32'(ctl.estado), 2);
    cyc(1, 0, 0);
    chk("arm_ignored_mem", 32'(ctl.memoria), 1);
    chk("arm_ignored_st", 32'(ctl.estado), 2);
    cyc(0, 0, 4'b0100);
    chk("immediate_st", 32'(ctl.estado), 4);
    chk("immediate_sir", 32'(ctl.sirene), 1);
    cyc(0, 1, 0);
    chk("disarm_siren_off", 32'(ctl.sirene), 0);
    cyc(1, 0, 0);
    repeat (EXD) cyc(0, 0, 0);
    cyc(0, 0, 4'b0001);
    cyc(0, 0, 4'b0100);
    chk("entrada_to_disparo", 32'(ctl.estado), 4);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (EXD) cyc(0, 0, 0);
    cyc(0, 0, 4'b0100);
    k = 0;
    while (ctl.estado == 3'd4 && k < 40) begin cyc(0, 0, 4'b0100); k++; end
    chk("stuck_timeout", 32'(ctl.estado), 2);
    repeat (3) cyc(0, 0, 4'b0100);
    chk("no_retrigger", 32'(ctl.estado), 2);
    cyc(0, 0, 4'b1000);
    chk("new_zone", 32'(ctl.estado), 4);
    chk("mem_1100", 32'(ctl.memoria), 32'h0000_000c);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_sir", 32'(ctl.sirene), 0);
    chk("async_rst_st", 32'(ctl.estado), 0);
    chk("async_rst_mem", 32'(ctl.memoria), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0);
    chk("post_rst_arm", 32'(ctl.estado), 1);
    repeat (EXD) cyc(0, 0, 0);
    cyc(0, 0, 4'hf);
    k = 0;
    while (ctl.estado == 3'd4 && k < 40) begin cyc(0, 0, 4'hf); k++; end
    repeat (20) cyc(0, 0, 4'($urandom));
    chk("all_bypassed", 32'(ctl.estado), 2);
    repeat (3000)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
          ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
